// File: rtl/mult_seq_ctrl.sv
// mult_seq_ctrl: button synchronizers and add/shift sequencer for the signed shift-add multiplier
module mult_seq_ctrl #(
    parameter int N           = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic Clk,
    input  logic Reset_n,
    input  logic Execute,
    input  logic ClearA_loadB,
    input  logic B_lsb,
    output logic Clr_AX,
    output logic Ld_B,
    output logic Ld_AX,
    output logic Sub_sel,
    output logic Shift_en,
    output logic Busy,
    output logic Done
);
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [2:0] {IDLE, LOADB, CLR, ADD, SHIFT, HOLD} state_t;

    state_t state, state_next;
    logic [SYNC_STAGES-1:0] ex_sync, ld_sync;
    logic ex_hist, ld_hist;
    logic [CW-1:0] count;
    logic ex_pulse, ld_pulse, last;

    assign ex_pulse = ex_sync[SYNC_STAGES-1] & ~ex_hist;
    assign ld_pulse = ld_sync[SYNC_STAGES-1] & ~ld_hist;
    assign last     = count == CW'(N - 1);

    // history flops update in every state, so presses outside IDLE are dropped rather than queued
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            ex_sync <= '0;
            ld_sync <= '0;
            ex_hist <= 1'b0;
            ld_hist <= 1'b0;
            state   <= IDLE;
            count   <= '0;
        end else begin
            ex_sync <= {ex_sync[SYNC_STAGES-2:0], Execute};
            ld_sync <= {ld_sync[SYNC_STAGES-2:0], ClearA_loadB};
            ex_hist <= ex_sync[SYNC_STAGES-1];
            ld_hist <= ld_sync[SYNC_STAGES-1];
            state   <= state_next;
            if (state == CLR)
                count <= '0;
            else if (state == SHIFT && !last)
                count <= count + CW'(1);
        end
    end

    always_comb begin
        state_next = state;
        Clr_AX     = 1'b0;
        Ld_B       = 1'b0;
        Ld_AX      = 1'b0;
        Sub_sel    = 1'b0;
        Shift_en   = 1'b0;
        Busy       = 1'b0;
        Done       = 1'b0;
        case (state)
            IDLE:  state_next = ex_pulse ? CLR : ld_pulse ? LOADB : IDLE;
            LOADB: begin
                Ld_B       = 1'b1;
                Clr_AX     = 1'b1;
                state_next = IDLE;
            end
            CLR: begin
                Clr_AX     = 1'b1;
                Busy       = 1'b1;
                state_next = ADD;
            end
            ADD: begin
                Busy       = 1'b1;
                Ld_AX      = B_lsb;
                Sub_sel    = B_lsb & last;
                state_next = SHIFT;
            end
            SHIFT: begin
                Busy       = 1'b1;
                Shift_en   = 1'b1;
                state_next = last ? HOLD : ADD;
            end
            HOLD: begin
                Done       = 1'b1;
                state_next = ex_sync[SYNC_STAGES-1] ? HOLD : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end
endmodule

// File: tb/tb_mult_seq_ctrl.sv
// tb_mult_seq_ctrl: randomized runs of the sequencer against a cycle-timeline reference model
module tb_mult_seq_ctrl;
    logic Clk = 1'b0;
    logic Reset_n = 1'b0;
    logic Execute = 1'b0;
    logic ClearA_loadB = 1'b0;
    logic B_lsb;
    logic Clr_AX, Ld_B, Ld_AX, Sub_sel, Shift_en, Busy, Done;
    logic [7:0] b_val = 8'h00;
    int shifts = 0;
    int checks = 0;
    int failures = 0;

    mult_seq_ctrl #(.N(8), .SYNC_STAGES(2)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .Execute(Execute), .ClearA_loadB(ClearA_loadB),
        .B_lsb(B_lsb), .Clr_AX(Clr_AX), .Ld_B(Ld_B), .Ld_AX(Ld_AX), .Sub_sel(Sub_sel),
        .Shift_en(Shift_en), .Busy(Busy), .Done(Done)
    );

    always #5 Clk = ~Clk;

    // B register model: each shift exposes the next multiplier bit
    always @(posedge Clk) begin
        if (Clr_AX) shifts <= 0;
        else if (Shift_en) shifts <= shifts + 1;
    end
    assign B_lsb = (shifts < 8) ? b_val[shifts[2:0]] : 1'b0;

    function automatic logic [6:0] obs();
        return {Clr_AX, Ld_B, Ld_AX, Sub_sel, Shift_en, Busy, Done};
    endfunction

    // expected {Clr_AX,Ld_B,Ld_AX,Sub_sel,Shift_en,Busy,Done} after edge c of an Execute press
    function automatic logic [6:0] exp_run(input logic [7:0] b, input int c);
        int i;
        if (c < 2) return 7'b0;
        if (c == 2) return 7'b1000010;
        if (c >= 19) return 7'b0000001;
        i = (c - 3) / 2;
        if ((c - 3) % 2 == 0) return {2'b00, b[i], b[i] && i == 7, 3'b010};
        return 7'b0000110;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic idle_cycles(input string tag, input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge Clk);
            @(negedge Clk);
            chk(tag, 32'(obs()), 32'd0);
        end
    endtask

    task automatic run(input logic [7:0] b, input int hold, input bit ld_same, input bit ld_mid);
        int sh = 0;
        int done_cyc = -1;
        b_val = b;
        @(posedge Clk);
        #1 Execute = 1'b1;
        if (ld_same) ClearA_loadB = 1'b1;
        for (int c = 0; c < hold; c++) begin
            @(posedge Clk);
            @(negedge Clk);
            chk($sformatf("run b=%h c=%0d", b, c), 32'(obs()), 32'(exp_run(b, c)));
            if (Shift_en) sh++;
            if (Done && done_cyc < 0) done_cyc = c;
            if (ld_mid && c == 8) ClearA_loadB = 1'b1;
        end
        chk("shift_count", 32'(sh), 32'd8);
        chk("done_latency", 32'(done_cyc - 2), 32'd17);
        Execute = 1'b0;
        for (int r = 0; r < 3; r++) begin
            @(posedge Clk);
            @(negedge Clk);
            chk($sformatf("release r=%0d", r), 32'(obs()), (r < 2) ? 32'd1 : 32'd0);
        end
        idle_cycles("post_run_idle", 3);
        ClearA_loadB = 1'b0;
        idle_cycles("post_run_idle2", 3);
    endtask

    initial begin
        #12;
        chk("reset_outputs", 32'(obs()), 32'd0);
        @(posedge Clk);
        #1 Reset_n = 1'b1;
        idle_cycles("reset_release", 3);

        // ClearA_loadB held five cycles gives one LOADB cycle on edge 2
        @(posedge Clk);
        #1 ClearA_loadB = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(posedge Clk);
            @(negedge Clk);
            chk($sformatf("loadb c=%0d", c), 32'(obs()), (c == 2) ? 32'h60 : 32'd0);
            if (c == 4) ClearA_loadB = 1'b0;
        end

        run(8'h07, 22, 1'b0, 1'b0);
        run(8'h80, 22, 1'b0, 1'b0);
        run(8'h00, 22, 1'b0, 1'b0);
        run(8'hFF, 40, 1'b0, 1'b0);
        run(8'h5A, 22, 1'b0, 1'b0);
        run(8'(($urandom)), 22, 1'b1, 1'b0);
        run(8'(($urandom)), 24, 1'b0, 1'b1);
        for (int k = 0; k < 6; k++) begin
            idle_cycles("gap", 1 + int'($urandom_range(0, 4)));
            run(8'($urandom), 20 + int'($urandom_range(0, 10)), 1'($urandom), 1'($urandom));
        end

        // reset in the middle of ADD clears outputs at once and aborts the run
        b_val = 8'hFF;
        @(posedge Clk);
        #1 Execute = 1'b1;
        repeat (8) @(posedge Clk);
        @(negedge Clk);
        chk("pre_reset_add", 32'(obs()), 32'(exp_run(8'hFF, 7)));
        Reset_n = 1'b0;
        Execute = 1'b0;
        #1 chk("async_reset", 32'(obs()), 32'd0);
        @(posedge Clk);
        #1 Reset_n = 1'b1;
        idle_cycles("after_abort", 6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end
endmodule
